fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the immediate generator. Holds the program counter and fetches 32-bit words from instruction memory over a req/ready handshake. Presents each instruction with its PC to decode, where the immediate generator consumes it. Computes the next PC from the immediate the generator returns plus the control selection, and traps on misaligned targets.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the program counter, fetches 32-bit words from instruction memory over a
// req/ready handshake, presents the held instruction and its pc to decode, and
// computes the next pc from the returned immediate and the control select. A
// target that is not word-aligned raises a sticky trap and halts fetching until reset.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (address always equals pc)
//   imem_ready/rdata    memory response, sampled only while fetching
//   instruction(_valid) held instruction and its valid flag
//   pc, pc_plus4        address of the held instruction and its link value
//   instr_accept        consumer takes the held instruction; pc_sel, immediate and
//                       rs1_data are sampled with it
//   misaligned_trap     sticky misaligned-target flag
module fetch_unit #(
   parameter int unsigned        ADDR_LEN        = 32,
   parameter int unsigned        INSTRUCTION_LEN = 32,
   parameter logic [ADDR_LEN-1:0] RESET_PC       = '0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic                       imem_req,
   output logic [ADDR_LEN-1:0]        imem_addr,
   input  logic                       imem_ready,
   input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
   output logic [INSTRUCTION_LEN-1:0] instruction,
   output logic                       instruction_valid,
   output logic [ADDR_LEN-1:0]        pc,
   output logic [ADDR_LEN-1:0]        pc_plus4,
   input  logic                       instr_accept,
   input  logic [1:0]                 pc_sel,
   input  logic [ADDR_LEN-1:0]        immediate,
   input  logic [ADDR_LEN-1:0]        rs1_data,
   output logic                       misaligned_trap
);

   typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;

   state_e                     state_q, state_d;
   logic [ADDR_LEN-1:0]        pc_q, pc_d;
   logic [INSTRUCTION_LEN-1:0] instr_q, instr_d;
   logic                       trap_q, trap_d;
   logic [ADDR_LEN-1:0]        target;
   logic [ADDR_LEN-1:0]        jalr_sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         trap_q  <= trap_d;
      end
   end

   // Next-pc candidate; only meaningful while holding with an accept.
   always_comb begin
      jalr_sum = rs1_data + immediate;
      target   = pc_q + ADDR_LEN'(4);
      unique case (pc_sel)
         2'b01:   target = pc_q + immediate;
         2'b10:   target = {jalr_sum[ADDR_LEN-1:1], 1'b0};
         default: target = pc_q + ADDR_LEN'(4);
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      trap_d  = trap_q;
      unique case (state_q)
         StFetch: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = StHold;
            end
         end
         StHold: begin
            if (instr_accept) begin
               if (target[1:0] == 2'b00) begin
                  pc_d    = target;
                  state_d = StFetch;
               end else begin
                  // pc keeps the faulting instruction's address for the handler.
                  trap_d  = 1'b1;
                  state_d = StHalt;
               end
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      imem_req          = (state_q == StFetch);
      instruction_valid = (state_q == StHold);
      imem_addr         = pc_q;
      pc                = pc_q;
      pc_plus4          = pc_q + ADDR_LEN'(4);
      instruction       = instr_q;
      misaligned_trap   = trap_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        instruction_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_accept;
   logic [1:0]  pc_sel;
   logic [31:0] immediate;
   logic [31:0] rs1_data;
   logic        misaligned_trap;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: 0 = waiting for memory, 1 = instruction held, 2 = halted.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_trap;

   fetch_unit #(
      .ADDR_LEN        (32),
      .INSTRUCTION_LEN (32),
      .RESET_PC        (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .instruction       (instruction),
      .instruction_valid (instruction_valid),
      .pc                (pc),
      .pc_plus4          (pc_plus4),
      .instr_accept      (instr_accept),
      .pc_sel            (pc_sel),
      .immediate         (immediate),
      .rs1_data          (rs1_data),
      .misaligned_trap   (misaligned_trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".req"},   32'(imem_req),          32'(m_mode == 0));
      check({tag, ".valid"}, 32'(instruction_valid), 32'(m_mode == 1));
      check({tag, ".addr"},  imem_addr,              m_pc);
      check({tag, ".pc"},    pc,                     m_pc);
      check({tag, ".pc4"},   pc_plus4,               m_pc + 32'd4);
      check({tag, ".instr"}, instruction,            m_instr);
      check({tag, ".trap"},  32'(misaligned_trap),   32'(m_trap));
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_trap  = 1'b0;
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, update model, check.
   task automatic step(input string tag, input logic rdy, input logic [31:0] rdata,
                       input logic acc, input logic [1:0] sel,
                       input logic [31:0] imm, input logic [31:0] rs1);
      logic [31:0] t;
      imem_ready   = rdy;
      imem_rdata   = rdata;
      instr_accept = acc;
      pc_sel       = sel;
      immediate    = imm;
      rs1_data     = rs1;
      @(posedge clk);
      if (m_mode == 0 && rdy) begin
         m_instr = rdata;
         m_mode  = 1;
      end else if (m_mode == 1 && acc) begin
         if (sel == 2'd1)      t = m_pc + imm;
         else if (sel == 2'd2) t = ((rs1 + imm) / 2) * 2;
         else                  t = m_pc + 4;
         if (t % 4 == 0) begin
            m_pc   = t;
            m_mode = 0;
         end else begin
            m_trap = 1'b1;
            m_mode = 2;
         end
      end
      @(negedge clk);
      check_all(tag);
   endtask

   // Asserts reset a few ns after a negedge, away from any rising edge.
   task automatic async_reset(input string tag);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(negedge clk);
      check_all({tag, ".held"});
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b0;
      imem_ready   = 1'b0;
      imem_rdata   = '0;
      instr_accept = 1'b0;
      pc_sel       = 2'b00;
      immediate    = '0;
      rs1_data     = '0;
      model_reset();
      @(negedge clk);
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;
      check_all("post_reset");

      // Zero-wait memory, sequential accepts: 0,4,8,12.
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", imem_addr, 32'(i * 4));
         step("seq_fetch", 1'b1, 32'h0000_0013, 1'b0, 2'b00, 32'h0, 32'h0);
         step("seq_acc",   1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      end
      // Branch at 16 back to 8.
      step("br_fetch", 1'b1, 32'hfe00_0ce3, 1'b0, 2'b00, 32'h0, 32'h0);
      step("br_acc",   1'b0, 32'h0, 1'b1, 2'b01, 32'hffff_fff8, 32'h0);
      check("br_target", imem_addr, 32'h8);
      // Memory stalls at pc=8.
      for (int i = 0; i < 5; i++)
         step("stall", 1'b0, 32'hdead_beef, 1'b1, 2'b01, 32'h40, 32'h0);
      step("stall_end", 1'b1, 32'h1000_006f, 1'b0, 2'b00, 32'h0, 32'h0);
      check("stall_instr", instruction, 32'h1000_006f);
      // JAL from 8 to 0x108.
      step("jal_acc", 1'b0, 32'h0, 1'b1, 2'b01, 32'h100, 32'h0);
      check("jal_target", imem_addr, 32'h108);
      // JALR 0x201+3 -> 0x204.
      step("jalr_fetch", 1'b1, 32'h0030_8067, 1'b0, 2'b00, 32'h0, 32'h0);
      step("jalr_acc",   1'b0, 32'h0, 1'b1, 2'b10, 32'h3, 32'h201);
      check("jalr_target", imem_addr, 32'h204);
      // Hold without accept while other inputs toggle.
      step("hold_fetch", 1'b1, 32'h1234_5678, 1'b0, 2'b00, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++)
         step("hold", 1'(i), 32'hffff_ffff, 1'b0, 2'(i), 32'h10, 32'h20);
      check("hold_instr", instruction, 32'h1234_5678);
      // Jump to 0xFFFF_FFFC, then wrap to 0.
      step("to_top", 1'b0, 32'h0, 1'b1, 2'b10, 32'h4, 32'hffff_fff8);
      check("top_addr", imem_addr, 32'hffff_fffc);
      step("top_fetch", 1'b1, 32'h0000_0013, 1'b0, 2'b00, 32'h0, 32'h0);
      step("wrap_acc",  1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);
      // Misaligned JALR 0x201+1 -> 0x202 traps, pc stays 0.
      step("mis_fetch", 1'b1, 32'h0010_8067, 1'b0, 2'b00, 32'h0, 32'h0);
      step("mis_acc",   1'b0, 32'h0, 1'b1, 2'b10, 32'h1, 32'h201);
      check("mis_trap", 32'(misaligned_trap), 32'd1);
      check("mis_req",  32'(imem_req), 32'd0);
      check("mis_pc",   pc, 32'h0);
      for (int i = 0; i < 3; i++)
         step("halt", 1'b1, 32'h13, 1'b1, 2'b00, 32'h0, 32'h0);
      async_reset("rst_halt");
      // Reset in the middle of a stalled fetch.
      step("mid_fetch", 1'b1, 32'h13, 1'b0, 2'b00, 32'h0, 32'h0);
      step("mid_acc",   1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
      step("mid_stall", 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      async_reset("rst_fetch");

      // Random traffic; immediates are mostly aligned so traps stay occasional.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] imm;
         logic [31:0] rs1;
         imm = $urandom();
         rs1 = $urandom();
         if ($urandom_range(0, 7) != 0) begin
            imm[1:0] = 2'b00;
            rs1[1:0] = 2'b00;
         end
         step("rand", 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), imm, rs1);
         if (m_mode == 2 && $urandom_range(0, 3) == 0) async_reset("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
